// File: rtl/ct_f_spsram_param_init.sv
// Single-port SRAM with a hardware clear that zeroes every word after reset or on INIT_REQ.
// Define CT_F_SPSRAM_OUTREG_EN to add an output pipeline register (read latency 2).
module ct_f_spsram_param_init #(
    parameter int WIDTH      = 7,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WIDTH-1:0]      WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [WIDTH-1:0]      D,
    input  logic                  INIT_REQ,
    output logic [WIDTH-1:0]      Q,
    output logic                  INIT_BUSY
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic                  r_busy;
    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [WIDTH-1:0]      r_q_p1;

    logic                  w_acc;
    logic                  w_addr_ok;
    logic                  w_wr;
    logic [WIDTH-1:0]      w_rd_word;
    logic [WIDTH-1:0]      w_merged;

    // Addresses past the last word (non power-of-two DEPTH) read as zero and never write.
    assign w_acc     = (r_state == ST_READY) && !CEN;
    assign w_addr_ok = ({1'b0, A} < DEPTH_EXT);
    assign w_rd_word = w_addr_ok ? r_mem[A] : '0;
    assign w_merged  = (w_rd_word & WEN) | (D & ~WEN);
    assign w_wr      = w_acc && !GWEN && w_addr_ok;

    // Storage carries no reset so it maps onto a memory macro / inferred RAM.
    always_ff @(posedge CLK) begin
        if (r_state == ST_INIT) begin
            r_mem[r_addr_cnt] <= '0;
        end else if (w_wr) begin
            r_mem[A] <= w_merged;
        end
    end

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state    <= ST_INIT;
            r_addr_cnt <= '0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_addr_cnt == LAST_ADDR) begin
                        r_state    <= ST_READY;
                        r_addr_cnt <= '0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_addr_cnt <= r_addr_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (INIT_REQ) begin
                        r_state    <= ST_INIT;
                        r_addr_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_addr_cnt <= '0;
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

    // Stage 1: write-first read data; holds when there is no access.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_q_p1 <= '0;
        end else if (w_acc) begin
            r_q_p1 <= w_wr ? w_merged : w_rd_word;
        end
    end

`ifdef CT_F_SPSRAM_OUTREG_EN
    logic             r_vld_p1;
    logic [WIDTH-1:0] r_q_p2;

    // Stage 2: optional output register, advances only behind a completed access.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_vld_p1 <= 1'b0;
            r_q_p2   <= '0;
        end else begin
            r_vld_p1 <= w_acc;
            if (r_vld_p1) begin
                r_q_p2 <= r_q_p1;
            end
        end
    end

    assign Q = r_q_p2;
`else
    assign Q = r_q_p1;
`endif

    assign INIT_BUSY = r_busy;

endmodule

// File: tb/tb_ct_f_spsram_param_init.sv
// Randomized self-checking bench for ct_f_spsram_param_init with a word-array reference model.
// A second instance with DEPTH=200 exercises out-of-range addressing.
module tb_ct_f_spsram_param_init;

    localparam int W    = 7;
    localparam int DEP  = 256;
    localparam int AW   = 8;
    localparam int DEP2 = 200;
`ifdef CT_F_SPSRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          cen = 1'b1, gwen = 1'b1, ireq = 1'b0;
    logic [W-1:0]  wen = '1, d = '0;
    logic [AW-1:0] a = '0;
    logic [W-1:0]  q;
    logic          busy;

    logic          cen2 = 1'b1, gwen2 = 1'b1, ireq2 = 1'b0;
    logic [W-1:0]  wen2 = '1, d2 = '0;
    logic [AW-1:0] a2 = '0;
    logic [W-1:0]  q2;
    logic          busy2;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] m [DEP];
    int           init_left;
    logic [W-1:0] hist [$];

    ct_f_spsram_param_init #(.WIDTH(W), .DEPTH(DEP), .ADDR_WIDTH(AW)) dut (
        .CLK(clk), .cpurst_b(rst_b), .CEN(cen), .GWEN(gwen), .WEN(wen), .A(a), .D(d),
        .INIT_REQ(ireq), .Q(q), .INIT_BUSY(busy)
    );

    ct_f_spsram_param_init #(.WIDTH(W), .DEPTH(DEP2), .ADDR_WIDTH(AW)) dut2 (
        .CLK(clk), .cpurst_b(rst_b), .CEN(cen2), .GWEN(gwen2), .WEN(wen2), .A(a2), .D(d2),
        .INIT_REQ(ireq2), .Q(q2), .INIT_BUSY(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_after_reset();
        for (int i = 0; i < DEP; i++) m[i] = '0;
        init_left = DEP;
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
    endtask

    // One clock of the main instance; model predicts Q (with latency) and INIT_BUSY.
    task automatic step(input logic c, input logic g, input logic [W-1:0] we,
                        input logic [AW-1:0] ad, input logic [W-1:0] dd, input logic rq);
        logic [W-1:0] res;
        logic         exp_busy;
        res = hist[hist.size()-1];
        cen = c; gwen = g; wen = we; a = ad; d = dd; ireq = rq;
        @(posedge clk);
        #1;
        if (init_left > 0) begin
            init_left--;
        end else begin
            if (!c) begin
                if (!g) m[ad] = (m[ad] & we) | (dd & ~we);
                res = m[ad];
            end
            if (rq) begin
                for (int i = 0; i < DEP; i++) m[i] = '0;
                init_left = DEP;
            end
        end
        hist.push_back(res);
        if (hist.size() > 8) void'(hist.pop_front());
        cen = 1'b1; ireq = 1'b0;
        exp_busy = (init_left > 0);
        checks++;
        if (q !== hist[hist.size()-LAT]) begin
            failures++;
            $display("FAIL step_q: got %h expected %h (addr %h)", q, hist[hist.size()-LAT], ad);
        end
        checks++;
        if (busy !== exp_busy) begin
            failures++;
            $display("FAIL step_busy: got %b expected %b", busy, exp_busy);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, '1, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        int n1, n2;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q !== '0) begin failures++; $display("FAIL reset_q: got %h expected 00", q); end
        checks++;
        if (busy !== 1'b1 || busy2 !== 1'b1) begin
            failures++; $display("FAIL reset_busy: got %b/%b expected 1/1", busy, busy2);
        end
        @(negedge clk);
        rst_b = 1'b1;
        model_after_reset();
        n1 = 0; n2 = 0;
        for (int i = 1; i <= 400 && (busy || busy2); i++) begin
            step(1'b1, 1'b1, '1, '0, '0, 1'b0);
            if (!busy && n1 == 0) n1 = i;
            if (!busy2 && n2 == 0) n2 = i;
        end
        checks++;
        if (n1 != DEP) begin failures++; $display("FAIL clear_cycles: got %0d expected %0d", n1, DEP); end
        checks++;
        if (n2 != DEP2) begin failures++; $display("FAIL clear_cycles_d200: got %0d expected %0d", n2, DEP2); end
    endtask

    task automatic test_cleared_reads();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, W'($urandom), AW'($urandom), W'($urandom), 1'b0);
        idle(LAT);
    endtask

    task automatic test_write_mask_and_initreq();
        int n;
        step(1'b0, 1'b0, 7'h00, 8'h3C, 7'h55, 1'b0);
        idle(LAT - 1);
        checks++;
        if (q !== 7'h55) begin failures++; $display("FAIL write_first: got %h expected 55", q); end
        step(1'b0, 1'b1, 7'h00, 8'h3C, 7'h00, 1'b0);
        idle(LAT - 1);
        checks++;
        if (q !== 7'h55) begin failures++; $display("FAIL read_back: got %h expected 55", q); end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 7'h00, 8'h3C, 7'h22, 1'b0);
            checks++;
            if (q !== 7'h55) begin failures++; $display("FAIL cen_hold: got %h expected 55", q); end
        end
        step(1'b0, 1'b0, 7'h70, 8'h3C, 7'h7F, 1'b0);
        idle(LAT - 1);
        checks++;
        if (q !== 7'h5F) begin failures++; $display("FAIL bit_mask: got %h expected 5F", q); end
        step(1'b1, 1'b1, '1, '0, '0, 1'b1);
        n = 0;
        while (busy && n < 400) begin
            n++;
            step(1'($urandom), 1'($urandom), W'($urandom), AW'($urandom), W'($urandom), 1'($urandom));
        end
        checks++;
        if (n != DEP) begin failures++; $display("FAIL initreq_cycles: got %0d expected %0d", n, DEP); end
        step(1'b0, 1'b1, '1, 8'h3C, '0, 1'b0);
        idle(LAT - 1);
        checks++;
        if (q !== 7'h00) begin failures++; $display("FAIL read_after_clear: got %h expected 00", q); end
    endtask

    task automatic test_initreq_with_access();
        int n;
        step(1'b0, 1'b0, 7'h00, 8'h21, 7'h33, 1'b1);
        n = 0;
        while (busy && n < 400) begin n++; idle(1); end
        checks++;
        if (q !== 7'h33) begin failures++; $display("FAIL access_with_req: got %h expected 33", q); end
        step(1'b0, 1'b1, '1, 8'h21, '0, 1'b0);
        idle(LAT - 1);
        checks++;
        if (q !== 7'h00) begin failures++; $display("FAIL cleared_after_req: got %h expected 00", q); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom), W'($urandom),
                 8'hA0 + AW'($urandom_range(0, 15)), W'($urandom), 1'b0);
        end
        idle(LAT);
    endtask

    task automatic test_latency();
        logic [W-1:0] exp_first;
        step(1'b0, 1'b1, '1, 8'hF5, '0, 1'b0);
        idle(LAT);
        step(1'b0, 1'b0, 7'h00, 8'h3C, 7'h2A, 1'b0);
        exp_first = (LAT == 1) ? 7'h2A : 7'h00;
        checks++;
        if (q !== exp_first) begin failures++; $display("FAIL latency_edge1: got %h expected %h", q, exp_first); end
        step(1'b0, 1'b1, '1, 8'h3C, '0, 1'b0);
        checks++;
        if (q !== 7'h2A) begin failures++; $display("FAIL latency_edge2: got %h expected 2A", q); end
        idle(LAT);
    endtask

    task automatic test_out_of_range();
        cen2 = 1'b0; gwen2 = 1'b0; wen2 = '0; a2 = 8'hC7; d2 = 7'h11;
        step(1'b1, 1'b1, '1, '0, '0, 1'b0);
        a2 = 8'hC8; d2 = 7'h22;
        step(1'b1, 1'b1, '1, '0, '0, 1'b0);
        gwen2 = 1'b1; a2 = 8'hC7;
        step(1'b1, 1'b1, '1, '0, '0, 1'b0);
        cen2 = 1'b1;
        idle(LAT - 1);
        checks++;
        if (q2 !== 7'h11) begin failures++; $display("FAIL d200_in_range: got %h expected 11", q2); end
        cen2 = 1'b0; a2 = 8'hC8;
        step(1'b1, 1'b1, '1, '0, '0, 1'b0);
        cen2 = 1'b1;
        idle(LAT - 1);
        checks++;
        if (q2 !== 7'h00) begin failures++; $display("FAIL d200_oob_read: got %h expected 00", q2); end
        cen2 = 1'b0; a2 = 8'hC7;
        step(1'b1, 1'b1, '1, '0, '0, 1'b0);
        cen2 = 1'b1;
        idle(LAT - 1);
        checks++;
        if (q2 !== 7'h11) begin failures++; $display("FAIL d200_no_alias: got %h expected 11", q2); end
    endtask

    task automatic test_reset_mid_init();
        int n;
        step(1'b0, 1'b0, 7'h00, 8'h40, 7'h5A, 1'b0);
        idle(LAT);
        step(1'b1, 1'b1, '1, '0, '0, 1'b1);
        idle(99);
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (q !== 7'h00) begin failures++; $display("FAIL async_reset_q: got %h expected 00", q); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL async_reset_busy: got %b expected 1", busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        model_after_reset();
        n = 0;
        while (busy && n < 400) begin n++; idle(1); end
        checks++;
        if (n != DEP) begin failures++; $display("FAIL reclear_cycles: got %0d expected %0d", n, DEP); end
        step(1'b0, 1'b1, '1, 8'h40, '0, 1'b0);
        idle(LAT - 1);
        checks++;
        if (q !== 7'h00) begin failures++; $display("FAIL reclear_read: got %h expected 00", q); end
    endtask

    initial begin
        test_reset();
        test_cleared_reads();
        test_write_mask_and_initreq();
        test_initreq_with_access();
        test_back_to_back();
        test_latency();
        test_out_of_range();
        test_reset_mid_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
